ps2_rx: RTL and testbench

- PS/2 device-to-host serial receiver.
- Converts the raw PS2_CLK/PS2_DATA lines into a byte stream with single-cycle strobes.
- Sits directly upstream of the keyboard matrix decoder, which consumes DATA/VALID, and is a drop-in for its current receiver port list.
- Receive-only: never drives the PS/2 lines.

---
 rtl/ps2_pkg.sv | 23 ++
 rtl/ps2_line_filter.sv | 36 +++
 rtl/ps2_rx.sv | 129 ++++++++++++
 tb/tb_ps2_rx.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared PS/2 receive definitions: FSM states, frame constants and prefix codes
// used by both the receiver and the keyboard decoder.
package ps2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } ps2_state_t;

    localparam int unsigned FRAME_DATA_BITS = 8;
    localparam logic        ODD_PARITY      = 1'b1;

    localparam logic [7:0] EXT   = 8'hE0;
    localparam logic [7:0] BREAK = 8'hF0;

    // Data bits plus parity bit must hold an odd number of ones.
    function automatic logic parity_ok(input logic [FRAME_DATA_BITS-1:0] d, input logic p);
        return (^{d, p}) == ODD_PARITY;
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Two-flop synchronizer followed by a FILTER_LEN-sample agreement filter;
// the filtered level only changes once every sample in the window agrees.
module ps2_line_filter
    import ps2_pkg::*;
#(
    parameter int unsigned FILTER_LEN = 8
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_line,
    output logic o_level
);

    logic [1:0]            r_sync;
    logic [FILTER_LEN-1:0] r_shift;
    logic                  r_level;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync  <= '1;
            r_shift <= '1;
            r_level <= 1'b1;
        end else begin
            r_sync  <= {r_sync[0], i_line};
            r_shift <= {r_shift[FILTER_LEN-2:0], r_sync[1]};
            if (&r_shift) begin
                r_level <= 1'b1;
            end else if (~|r_shift) begin
                r_level <= 1'b0;
            end
        end
    end

    assign o_level = r_level;

endmodule

// File: rtl/ps2_rx.sv
// PS/2 device-to-host receiver: filters the raw lines, frames 11-bit words on
// filtered clock falls and emits one-cycle VALID/ERROR strobes with the byte.
module ps2_rx
    import ps2_pkg::*;
#(
    parameter int unsigned FILTER_LEN     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 2048
) (
    input  logic       CLK,
    input  logic       nRESET,
    input  logic       PS2_CLK,
    input  logic       PS2_DATA,
    output logic [7:0] DATA,
    output logic       VALID,
    output logic       ERROR,
    output logic       BUSY
);

    localparam int unsigned TO_W  = $clog2(TIMEOUT_CYCLES);
    localparam int unsigned CNT_W = $clog2(FRAME_DATA_BITS + 1);

    logic w_clk_filt;
    logic w_data_filt;

    logic                       r_clk_prev;
    logic                       r_fall;
    ps2_state_t                 r_state;
    logic [CNT_W-1:0]           r_bitcnt;
    logic [FRAME_DATA_BITS-1:0] r_shift;
    logic                       r_parity;
    logic [TO_W-1:0]            r_tocnt;
    logic [7:0]                 r_data;
    logic                       r_valid;
    logic                       r_error;
    logic                       r_busy;

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
        .i_clk   (CLK),
        .i_rst_n (nRESET),
        .i_line  (PS2_CLK),
        .o_level (w_clk_filt)
    );

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filter (
        .i_clk   (CLK),
        .i_rst_n (nRESET),
        .i_line  (PS2_DATA),
        .o_level (w_data_filt)
    );

    // One pulse per filtered high-to-low transition of the PS/2 clock.
    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            r_clk_prev <= 1'b1;
            r_fall     <= 1'b0;
        end else begin
            r_clk_prev <= w_clk_filt;
            r_fall     <= r_clk_prev & ~w_clk_filt;
        end
    end

    // Frame FSM; a fall pulse takes priority over a coincident timeout expiry.
    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            r_state  <= ST_IDLE;
            r_bitcnt <= '0;
            r_shift  <= '0;
            r_parity <= 1'b0;
            r_tocnt  <= '0;
            r_data   <= 8'h00;
            r_valid  <= 1'b0;
            r_error  <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            r_error <= 1'b0;
            if (r_state == ST_IDLE) begin
                r_tocnt <= '0;
                if (r_fall && !w_data_filt) begin
                    r_state  <= ST_DATA;
                    r_bitcnt <= '0;
                    r_busy   <= 1'b1;
                end
            end else if (r_fall) begin
                r_tocnt <= '0;
                case (r_state)
                    ST_DATA: begin
                        r_shift  <= {w_data_filt, r_shift[FRAME_DATA_BITS-1:1]};
                        r_bitcnt <= r_bitcnt + CNT_W'(1);
                        if (r_bitcnt == CNT_W'(FRAME_DATA_BITS - 1)) begin
                            r_state <= ST_PARITY;
                        end
                    end
                    ST_PARITY: begin
                        r_parity <= w_data_filt;
                        r_state  <= ST_STOP;
                    end
                    ST_STOP: begin
                        if (parity_ok(r_shift, r_parity) && w_data_filt) begin
                            r_data  <= r_shift;
                            r_valid <= 1'b1;
                        end else begin
                            r_error <= 1'b1;
                        end
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end else if (r_tocnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
                r_error <= 1'b1;
                r_state <= ST_IDLE;
                r_busy  <= 1'b0;
                r_tocnt <= '0;
            end else begin
                r_tocnt <= r_tocnt + TO_W'(1);
            end
        end
    end

    assign DATA  = r_data;
    assign VALID = r_valid;
    assign ERROR = r_error;
    assign BUSY  = r_busy;

endmodule

// File: tb/tb_ps2_rx.sv
// Directed bench for ps2_rx: PS/2 frames at 200 clk cycles per bit with
// hand-computed bytes, parities and strobe expectations.
module tb_ps2_rx;

    localparam int unsigned FILTER_LEN     = 8;
    localparam int unsigned TIMEOUT_CYCLES = 2048;
    localparam int          FALL_LATENCY   = 13;

    logic       clk;
    logic       rst_n;
    logic       ps2_clk;
    logic       ps2_data;
    logic [7:0] data;
    logic       valid;
    logic       error;
    logic       busy;

    int n_vec  = 0;
    int n_miss = 0;

    int cyc = 0;
    int last_fall_cyc = 0;
    int err_cyc = 0;
    int n_valid = 0;
    int n_error = 0;
    int n_both = 0;
    int n_wide = 0;
    int n_busy = 0;
    int n_vbusy = 0;
    logic prev_v = 1'b0;
    logic prev_e = 1'b0;
    logic [7:0] vlog[$];

    ps2_rx #(.FILTER_LEN(FILTER_LEN), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)) dut (
        .CLK      (clk),
        .nRESET   (rst_n),
        .PS2_CLK  (ps2_clk),
        .PS2_DATA (ps2_data),
        .DATA     (data),
        .VALID    (valid),
        .ERROR    (error),
        .BUSY     (busy)
    );

    initial clk = 1'b0;
    always #200 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Strobe bookkeeping sampled away from the active edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (valid) begin
                n_valid++;
                vlog.push_back(data);
                if (busy) n_vbusy++;
            end
            if (error) begin
                n_error++;
                err_cyc = cyc;
            end
            if (valid && error) n_both++;
            if ((valid && prev_v) || (error && prev_e)) n_wide++;
            if (busy) n_busy++;
        end
        prev_v = valid;
        prev_e = error;
    end

    task automatic ps2_bit(input logic b, input bit glitch);
        @(negedge clk);
        ps2_data = b;
        repeat (49) @(negedge clk);
        ps2_clk = 1'b0;
        last_fall_cyc = cyc;
        repeat (100) @(negedge clk);
        ps2_clk = 1'b1;
        if (glitch) begin
            repeat (20) @(negedge clk);
            ps2_clk = 1'b0;
            repeat (3) @(negedge clk);
            ps2_clk = 1'b1;
            repeat (27) @(negedge clk);
        end else begin
            repeat (50) @(negedge clk);
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par, input logic stp,
                              input int nbits, input bit glitch);
        logic [10:0] f;
        f = {stp, par, d, 1'b0};
        for (int i = 0; i < nbits; i++) ps2_bit(f[i], glitch);
        @(negedge clk);
        ps2_data = 1'b1;
        repeat (20) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        ps2_clk = 1'b1;
        ps2_data = 1'b1;
        repeat (5) @(negedge clk);
        n_vec += 4;
        if (data !== 8'h00) begin n_miss++; $display("FAIL reset_data got %h want 00", data); end
        if (valid !== 1'b0) begin n_miss++; $display("FAIL reset_valid got %b want 0", valid); end
        if (error !== 1'b0) begin n_miss++; $display("FAIL reset_error got %b want 0", error); end
        if (busy !== 1'b0) begin n_miss++; $display("FAIL reset_busy got %b want 0", busy); end
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
    endtask

    task automatic test_clean_frame();
        int v0, e0, b0;
        v0 = n_valid; e0 = n_error; b0 = n_busy;
        send_frame(8'h1C, 1'b0, 1'b1, 11, 1'b0);
        n_vec += 5;
        if (n_valid - v0 !== 1) begin n_miss++; $display("FAIL clean_valid_count got %0d want 1", n_valid - v0); end
        if (n_error - e0 !== 0) begin n_miss++; $display("FAIL clean_error_count got %0d want 0", n_error - e0); end
        if (data !== 8'h1C) begin n_miss++; $display("FAIL clean_data got %h want 1c", data); end
        if (n_busy - b0 !== 2000) begin n_miss++; $display("FAIL clean_busy_cycles got %0d want 2000", n_busy - b0); end
        if (busy !== 1'b0) begin n_miss++; $display("FAIL clean_busy_after got %b want 0", busy); end
    endtask

    task automatic test_back_to_back();
        int v0, e0, base;
        logic [7:0] exp_b[3];
        exp_b[0] = 8'hE0; exp_b[1] = 8'hF0; exp_b[2] = 8'h75;
        v0 = n_valid; e0 = n_error; base = vlog.size();
        send_frame(8'hE0, 1'b0, 1'b1, 11, 1'b0);
        send_frame(8'hF0, 1'b1, 1'b1, 11, 1'b0);
        send_frame(8'h75, 1'b0, 1'b1, 11, 1'b0);
        n_vec += 2;
        if (n_valid - v0 !== 3) begin n_miss++; $display("FAIL b2b_valid_count got %0d want 3", n_valid - v0); end
        if (n_error - e0 !== 0) begin n_miss++; $display("FAIL b2b_error_count got %0d want 0", n_error - e0); end
        for (int i = 0; i < 3; i++) begin
            n_vec++;
            if (base + i >= vlog.size()) begin
                n_miss++; $display("FAIL b2b_byte%0d got none want %h", i, exp_b[i]);
            end else if (vlog[base + i] !== exp_b[i]) begin
                n_miss++; $display("FAIL b2b_byte%0d got %h want %h", i, vlog[base + i], exp_b[i]);
            end
        end
    endtask

    task automatic test_bad_frames();
        int v0, e0;
        v0 = n_valid; e0 = n_error;
        send_frame(8'h00, 1'b0, 1'b1, 11, 1'b0);
        n_vec += 3;
        if (n_error - e0 !== 1) begin n_miss++; $display("FAIL parity_error_count got %0d want 1", n_error - e0); end
        if (n_valid - v0 !== 0) begin n_miss++; $display("FAIL parity_valid_count got %0d want 0", n_valid - v0); end
        if (data !== 8'h75) begin n_miss++; $display("FAIL parity_data_hold got %h want 75", data); end
        v0 = n_valid; e0 = n_error;
        send_frame(8'h00, 1'b1, 1'b0, 11, 1'b0);
        n_vec += 3;
        if (n_error - e0 !== 1) begin n_miss++; $display("FAIL stop_error_count got %0d want 1", n_error - e0); end
        if (n_valid - v0 !== 0) begin n_miss++; $display("FAIL stop_valid_count got %0d want 0", n_valid - v0); end
        if (data !== 8'h75) begin n_miss++; $display("FAIL stop_data_hold got %h want 75", data); end
    endtask

    task automatic test_timeout();
        int v0, e0, lat;
        v0 = n_valid; e0 = n_error;
        send_frame(8'h29, 1'b0, 1'b1, 5, 1'b0);
        for (int i = 0; i < 3000 && n_error == e0; i++) @(negedge clk);
        lat = err_cyc - last_fall_cyc;
        n_vec += 4;
        if (n_error - e0 !== 1) begin n_miss++; $display("FAIL timeout_error_count got %0d want 1", n_error - e0); end
        if (lat < int'(TIMEOUT_CYCLES) + FALL_LATENCY - 2 || lat > int'(TIMEOUT_CYCLES) + FALL_LATENCY + 2) begin
            n_miss++; $display("FAIL timeout_latency got %0d want %0d", lat, int'(TIMEOUT_CYCLES) + FALL_LATENCY);
        end
        repeat (2) @(negedge clk);
        if (busy !== 1'b0) begin n_miss++; $display("FAIL timeout_busy got %b want 0", busy); end
        if (n_valid - v0 !== 0) begin n_miss++; $display("FAIL timeout_valid_count got %0d want 0", n_valid - v0); end
        v0 = n_valid;
        send_frame(8'h29, 1'b0, 1'b1, 11, 1'b0);
        n_vec += 2;
        if (n_valid - v0 !== 1) begin n_miss++; $display("FAIL after_timeout_valid got %0d want 1", n_valid - v0); end
        if (data !== 8'h29) begin n_miss++; $display("FAIL after_timeout_data got %h want 29", data); end
    endtask

    task automatic test_glitch();
        int v0, e0, b0;
        v0 = n_valid; e0 = n_error;
        send_frame(8'h5A, 1'b1, 1'b1, 11, 1'b1);
        n_vec += 3;
        if (n_valid - v0 !== 1) begin n_miss++; $display("FAIL glitch_valid_count got %0d want 1", n_valid - v0); end
        if (n_error - e0 !== 0) begin n_miss++; $display("FAIL glitch_error_count got %0d want 0", n_error - e0); end
        if (data !== 8'h5A) begin n_miss++; $display("FAIL glitch_data got %h want 5a", data); end
        v0 = n_valid; e0 = n_error; b0 = n_busy;
        @(negedge clk);
        ps2_clk = 1'b0;
        repeat (3) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (40) @(negedge clk);
        n_vec += 2;
        if (n_busy - b0 !== 0) begin n_miss++; $display("FAIL idle_glitch_busy got %0d want 0", n_busy - b0); end
        if ((n_valid - v0) + (n_error - e0) !== 0) begin
            n_miss++; $display("FAIL idle_glitch_strobes got %0d want 0", (n_valid - v0) + (n_error - e0));
        end
    endtask

    task automatic test_reset_midframe();
        int v0, e0;
        v0 = n_valid; e0 = n_error;
        send_frame(8'h66, 1'b1, 1'b1, 6, 1'b0);
        n_vec++;
        if (busy !== 1'b1) begin n_miss++; $display("FAIL midframe_busy got %b want 1", busy); end
        rst_n = 1'b0;
        #1;
        n_vec += 2;
        if (data !== 8'h00) begin n_miss++; $display("FAIL midreset_data got %h want 00", data); end
        if ({valid, error, busy} !== 3'b000) begin
            n_miss++; $display("FAIL midreset_flags got %b want 000", {valid, error, busy});
        end
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (200) @(negedge clk);
        n_vec++;
        if ((n_valid - v0) + (n_error - e0) !== 0) begin
            n_miss++; $display("FAIL midreset_strobes got %0d want 0", (n_valid - v0) + (n_error - e0));
        end
        send_frame(8'h66, 1'b1, 1'b1, 11, 1'b0);
        n_vec += 2;
        if (n_valid - v0 !== 1) begin n_miss++; $display("FAIL after_reset_valid got %0d want 1", n_valid - v0); end
        if (data !== 8'h66) begin n_miss++; $display("FAIL after_reset_data got %h want 66", data); end
    endtask

    task automatic test_strobe_rules();
        n_vec += 3;
        if (n_both !== 0) begin n_miss++; $display("FAIL valid_and_error got %0d want 0", n_both); end
        if (n_wide !== 0) begin n_miss++; $display("FAIL strobe_width got %0d want 0", n_wide); end
        if (n_vbusy !== 0) begin n_miss++; $display("FAIL busy_at_valid got %0d want 0", n_vbusy); end
    endtask

    initial begin
        test_reset();
        test_clean_frame();
        test_back_to_back();
        test_bad_frames();
        test_timeout();
        test_glitch();
        test_reset_midframe();
        test_strobe_rules();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
